// File: rtl/phase_sequencer_pkg.sv
// Shared definitions for the phase sequencer: FSM state encoding and the
// phase index width helper.
package phase_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_FIN  = 2'd3
   } state_e;

   function automatic int phase_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/phase_sequencer_prescaler.sv
// Synchronous up-only modulo-PRESCALE counter; TC is high while the count
// sits at PRESCALE-1. CLR has priority over ENABLE.
module phase_prescaler #(
   parameter int PRESCALE = 5
) (
   input  logic CLK,
   input  logic RSTn,
   input  logic CLR,
   input  logic ENABLE,
   output logic TC
);

   localparam int CW = $clog2(PRESCALE);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   assign TC = (count_q == CW'(PRESCALE - 1));

   always_comb begin
      count_d = count_q;
      if (CLR) begin
         count_d = '0;
      end else if (ENABLE) begin
         count_d = TC ? '0 : count_q + CW'(1);
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/phase_sequencer.sv
// Programmable multi-phase timer: walks N_PHASES phases, each lasting a
// programmable number of prescaled ticks. Optional macro PHASE_SEQUENCER_LOOP_EN
// makes the sequence repeat until STOP instead of ending through FIN.
module phase_sequencer
   import phase_sequencer_pkg::*;
#(
   parameter int N_PHASES  = 4,
   parameter int DUR_W     = 8,
   parameter int PRESCALE  = 5,
   parameter int DEF_DUR   = 1,
   localparam int PW       = phase_w(N_PHASES)
) (
   input  logic             CLK,
   input  logic             RSTn,
   input  logic             START,
   input  logic             STOP,
   input  logic             DUR_LOAD,
   input  logic [PW-1:0]    DUR_IDX,
   input  logic [DUR_W-1:0] DUR_VAL,
   output logic [PW-1:0]    PHASE,
   output logic             TICK,
   output logic             PHASE_END,
   output logic             DONE,
   output logic             BUSY,
   output logic [1:0]       dbg_state
);

   state_e           state_q, state_d;
   logic [PW-1:0]    phase_q, phase_d;
   logic [DUR_W-1:0] rem_q, rem_d;
   logic [DUR_W-1:0] dur_q [N_PHASES];
   logic [DUR_W-1:0] dur_d [N_PHASES];
   logic [DUR_W-1:0] dur_sel;
   logic             presc_tc;
   logic             tick_w;
   logic             last_tick;
   logic             last_phase;

   phase_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
      .CLK    (CLK),
      .RSTn   (RSTn),
      .CLR    ((state_q == ST_LOAD) || STOP),
      .ENABLE (state_q == ST_RUN),
      .TC     (presc_tc)
   );

   assign tick_w     = (state_q == ST_RUN) && presc_tc;
   assign last_tick  = tick_w && (rem_q <= DUR_W'(1));
   assign last_phase = (phase_q == PW'(N_PHASES - 1));

   // Out-of-range indices match no entry, so such writes are dropped.
   always_comb begin
      dur_sel = '0;
      for (int i = 0; i < N_PHASES; i++) begin
         dur_d[i] = dur_q[i];
         if (DUR_LOAD && (DUR_IDX == PW'(i))) dur_d[i] = DUR_VAL;
         if (phase_q == PW'(i)) dur_sel = dur_q[i];
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q <= ST_IDLE;
         phase_q <= '0;
         rem_q   <= '0;
         for (int i = 0; i < N_PHASES; i++) dur_q[i] <= DUR_W'(DEF_DUR);
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         rem_q   <= rem_d;
         for (int i = 0; i < N_PHASES; i++) dur_q[i] <= dur_d[i];
      end
   end

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      rem_d   = rem_q;
      case (state_q)
         ST_IDLE: if (START) begin
            state_d = ST_LOAD;
            phase_d = '0;
         end
         ST_LOAD: begin
            state_d = ST_RUN;
            rem_d   = (dur_sel == '0) ? DUR_W'(1) : dur_sel;
         end
         ST_RUN: begin
            if (last_tick) begin
               if (!last_phase) begin
                  state_d = ST_LOAD;
                  phase_d = phase_q + PW'(1);
               end else begin
`ifdef PHASE_SEQUENCER_LOOP_EN
                  state_d = ST_LOAD;
                  phase_d = '0;
`else
                  state_d = ST_FIN;
`endif
               end
            end else if (tick_w) begin
               rem_d = rem_q - DUR_W'(1);
            end
         end
         ST_FIN: begin
            state_d = ST_IDLE;
            phase_d = '0;
         end
         default: state_d = ST_IDLE;
      endcase
      // STOP overrides everything, including a START seen in IDLE.
      if (STOP) begin
         state_d = ST_IDLE;
         phase_d = '0;
      end
   end

   always_comb begin
      PHASE     = phase_q;
      TICK      = tick_w;
      PHASE_END = last_tick && !STOP;
`ifdef PHASE_SEQUENCER_LOOP_EN
      DONE      = last_tick && last_phase && !STOP;
`else
      DONE      = (state_q == ST_FIN) && !STOP;
`endif
      BUSY      = (state_q == ST_LOAD) || (state_q == ST_RUN);
      dbg_state = state_q;
   end

endmodule

// File: tb/tb_phase_sequencer.sv
// Scoreboard bench for phase_sequencer (N_PHASES=3, PRESCALE=5): drivers push
// expected PHASE_END/DONE events; a negedge monitor pops and compares them.
module tb_phase_sequencer;

  localparam int NP = 3;
  localparam int DW = 8;
  localparam int PS = 5;
  localparam int PW = 2;

  logic          CLK = 1'b0;
  logic          RSTn = 1'b0;
  logic          START = 1'b0;
  logic          STOP = 1'b0;
  logic          DUR_LOAD = 1'b0;
  logic [PW-1:0] DUR_IDX = '0;
  logic [DW-1:0] DUR_VAL = '0;
  logic [PW-1:0] PHASE;
  logic          TICK, PHASE_END, DONE, BUSY;
  logic [1:0]    dbg_state;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_got;

  phase_sequencer #(.N_PHASES(NP), .DUR_W(DW), .PRESCALE(PS), .DEF_DUR(1)) dut (
    .CLK(CLK), .RSTn(RSTn), .START(START), .STOP(STOP),
    .DUR_LOAD(DUR_LOAD), .DUR_IDX(DUR_IDX), .DUR_VAL(DUR_VAL),
    .PHASE(PHASE), .TICK(TICK), .PHASE_END(PHASE_END), .DONE(DONE),
    .BUSY(BUSY), .dbg_state(dbg_state)
  );

  // clock / cycle counter
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  // event word: {DONE, PHASE_END, PHASE, cycle}
  function automatic logic [31:0] ev(input logic d, input logic p, input int ph, input int c);
    return {d, p, ph[1:0], c[27:0]};
  endfunction

  // monitor
  always @(negedge CLK) begin
    if (RSTn && (PHASE_END || DONE)) begin
      mon_got = {DONE, PHASE_END, PHASE, 28'(cyc)};
      if (PHASE_END) check("pe_implies_tick", 32'(TICK), 32'd1);
`ifndef PHASE_SEQUENCER_LOOP_EN
      if (DONE) check("done_without_tick", 32'(TICK), 32'd0);
`endif
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_event: got %0h required none", mon_got);
      end else begin
        check("event", mon_got, exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) step();
  endtask

  task automatic write_dur(input int idx, input int val);
    DUR_LOAD = 1'b1;
    DUR_IDX  = 2'(idx);
    DUR_VAL  = 8'(val);
    step();
    DUR_LOAD = 1'b0;
  endtask

  task automatic start_seq(output int l);
    START = 1'b1;
    l = cyc + 1;
    step();
    START = 1'b0;
  endtask

  // e0..e2: hand-computed cycle (1-based from LOAD entry) of each PHASE_END
  task automatic expect_seq(input int l, input int e0, input int e1, input int e2);
    exp_q.push_back(ev(1'b0, 1'b1, 0, l + e0 - 1));
    exp_q.push_back(ev(1'b0, 1'b1, 1, l + e1 - 1));
    exp_q.push_back(ev(1'b0, 1'b1, 2, l + e2 - 1));
    exp_q.push_back(ev(1'b1, 1'b0, 2, l + e2));
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic check_idle(input string name);
    check(name, 32'({BUSY, PHASE, dbg_state}), 32'd0);
  endtask

  initial begin
    int l;
    repeat (3) step();
    check("reset_outputs", 32'({PHASE, TICK, PHASE_END, DONE, BUSY, dbg_state}), 32'd0);
    RSTn = 1'b1;
    step();
`ifndef PHASE_SEQUENCER_LOOP_EN
    // reset durations are all 1 tick: 6 cycles per phase
    start_seq(l);
    expect_seq(l, 6, 12, 18);
    drain("default_dur_run", 100);
    check_idle("default_dur_idle");

    write_dur(0, 2);
    write_dur(1, 1);
    write_dur(2, 3);

    start_seq(l);
    expect_seq(l, 11, 17, 33);
    drain("basic_run", 100);
    check_idle("basic_idle");

    // zero duration behaves as one tick
    write_dur(1, 0);
    start_seq(l);
    expect_seq(l, 11, 17, 33);
    drain("zero_dur_run", 100);
    check_idle("zero_dur_idle");
    write_dur(1, 1);

    // STOP in phase 1: only phase 0 end is expected
    start_seq(l);
    exp_q.push_back(ev(1'b0, 1'b1, 0, l + 10));
    wait_cyc(l + 13);
    STOP = 1'b1;
    step();
    STOP = 1'b0;
    check_idle("stop_idle");
    drain("stop_events", 5);
    repeat (40) step();
    start_seq(l);
    expect_seq(l, 11, 17, 33);
    drain("restart_run", 100);
    check_idle("restart_idle");

    // START+STOP together in IDLE
    START = 1'b1;
    STOP  = 1'b1;
    step();
    START = 1'b0;
    STOP  = 1'b0;
    check_idle("start_stop_idle");

    // START during RUN is ignored
    start_seq(l);
    expect_seq(l, 11, 17, 33);
    wait_cyc(l + 13);
    START = 1'b1;
    step();
    START = 1'b0;
    drain("start_in_run", 100);
    check_idle("start_in_run_idle");

    // write to running phase 1 only takes effect next sequence
    start_seq(l);
    expect_seq(l, 11, 17, 33);
    wait_cyc(l + 12);
    write_dur(1, 4);
    drain("write_running", 100);
    write_dur(3, 9);
    start_seq(l);
    expect_seq(l, 11, 32, 48);
    drain("new_dur_run", 100);
    check_idle("new_dur_idle");

    // async reset in phase 2
    start_seq(l);
    exp_q.push_back(ev(1'b0, 1'b1, 0, l + 10));
    exp_q.push_back(ev(1'b0, 1'b1, 1, l + 31));
    wait_cyc(l + 35);
    check("phase2_before_reset", 32'(PHASE), 32'd2);
    RSTn = 1'b0;
    #1;
    check("async_reset_outputs", 32'({PHASE, TICK, PHASE_END, DONE, BUSY, dbg_state}), 32'd0);
    step();
    RSTn = 1'b1;
    step();
    drain("pre_reset_events", 1);
    start_seq(l);
    expect_seq(l, 6, 12, 18);
    drain("post_reset_run", 100);
    check_idle("post_reset_idle");
`else
    write_dur(0, 2);
    write_dur(1, 1);
    write_dur(2, 3);
    start_seq(l);
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(ev(1'b0, 1'b1, 0, l + 33 * k + 10));
      exp_q.push_back(ev(1'b0, 1'b1, 1, l + 33 * k + 16));
      exp_q.push_back(ev(1'b1, 1'b1, 2, l + 33 * k + 32));
    end
    drain("loop_run", 200);
    check("loop_busy", 32'(BUSY), 32'd1);
    check("loop_phase", 32'(PHASE), 32'd0);
    STOP = 1'b1;
    step();
    STOP = 1'b0;
    check_idle("loop_stop_idle");
    repeat (40) step();
`endif
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
